simplez_kbd_fifo: RTL and testbench
===================================

Name: simplez_kbd_fifo

Overview:
- Keyboard peripheral for the Simplez CPU. Sits between the UART receiver and the CPU's keyboard status/data ports (addresses 510/511).
- Buffers received bytes in a FIFO so that keystrokes arriving while the CPU is busy (WAIT, long loops) are not lost.
- Presents the CPU-facing registers: a status byte and a data byte.
- Pops exactly one byte per CPU read, even though the CPU's address-decode chip selects stay high for several cycles per instruction.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries). Legal range 1..8.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous reset, active-low
- rx_data  in  8  byte from the UART receiver; valid when rx_rcv=1
- rx_rcv  in  1  one-cycle pulse: new byte received
- data_cs  in  1  CPU chip select for keyboard data (addr 511); level, may stay high for many cycles
- status_cs  in  1  CPU chip select for keyboard status (addr 510); level
- dout  out  8  keyboard data register presented to the CPU bus
- status  out  8  keyboard status register presented to the CPU bus
- count  out  DEPTH_LOG2+1  current FIFO occupancy, for debug/LEDs
- not_empty  out  1  combinational, count != 0

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Clears the read pointer, write pointer and count; FIFO contents are don't-care.
  - dout=0, status=0, overflow flag=0, edge-detect registers=0.
  - Reset mid-operation flushes all buffered bytes; an rx_rcv in the reset cycle is ignored.
- Edge detection:
  - data_q and status_q register the cs inputs each cycle.
  - pop_req = data_cs & ~data_q.
  - stat_req = status_cs & ~status_q.
  - A chip select held high N cycles therefore produces exactly one request.
- Push: rx_rcv=1 while count < 2^DEPTH_LOG2 writes rx_data at wr_ptr, then wr_ptr+1, count+1.
- Pop: pop_req=1 while count > 0 loads dout with the byte at rd_ptr on that edge, then rd_ptr+1, count-1.
  - dout is valid the cycle after the cs rising edge and holds until the next successful pop.
- Pop when empty: dout loads 8'h00; pointers and count are unchanged.
- Simultaneous push and pop:
  - Not full, not empty: both happen, count unchanged.
  - Full: pop is performed first, so the push is accepted; no overflow.
  - Empty: the pop returns 8'h00 and the push is stored, count=1.
- Push when full without pop: byte dropped, overflow set to 1 (sticky).
- Pointers wrap modulo 2^DEPTH_LOG2. count is DEPTH_LOG2+1 bits so that full is distinguishable from empty.
- Status register:
  - Updated every cycle status_cs=1 to {5'b0, overflow, full, not_empty}, using the values before this edge's updates. Holds otherwise.
  - full = (count == 2^DEPTH_LOG2).
  - Bit 0 is the "data ready" flag; CPU software polls it with LD 510 / BZ.
- Overflow clear: overflow clears on the edge where stat_req=1, after being sampled into status.
  - If an overflowing push coincides with stat_req, overflow remains 1.
- Latency: an rx_rcv pulse at edge k gives not_empty=1 after edge k. A status read starting at edge k+1 or later reports bit0=1.

Test Plan:
- Reset, then push 8'h41 via rx_rcv pulse; hold status_cs 3 cycles → status=8'h01. Raise data_cs 4 cycles → dout=8'h41 one cycle after the rising edge, count 1→0. Exactly one pop.
- Push 3 bytes 8'h61, 8'h62, 8'h63; perform three separate data_cs pulses → dout sequence 61, 62, 63. Then status=8'h00.
- Push 17 bytes (0x00..0x10) with DEPTH_LOG2=4 → count=16, status=8'h07 on first read, 8'h03 on second read (overflow cleared). Drained bytes are 0x00..0x0F; 0x10 is dropped.
- FIFO full, rx_rcv with 8'hAA in the same cycle as the data_cs rising edge → pop returns oldest byte, 8'hAA accepted, count stays 16, overflow stays 0.
- Empty FIFO, data_cs rising edge → dout=8'h00, count=0. Same with a simultaneous rx_rcv of 8'h55 → dout=8'h00, count=1, next pop gives 8'h55.
- Push 5 bytes, assert rstn=0 one cycle mid-stream → count=0, dout=0, status=0. A subsequent push/pop round-trips correctly from index 0; 20 push/pop pairs verify pointer wrap.

Source files
------------

// File: rtl/simplez_kbd_fifo_if.sv
// simplez_kbd_fifo_if: UART-side and CPU-side signals of the Simplez keyboard FIFO
//   rx_data   [7:0]          received byte, valid while rx_rcv=1
//   rx_rcv                   one-cycle pulse: new byte received
//   data_cs                  CPU chip select for the data register (addr 511), level
//   status_cs                CPU chip select for the status register (addr 510), level
//   dout      [7:0]          data register seen by the CPU
//   status    [7:0]          status register {5'b0, overflow, full, not_empty}
//   count     [DEPTH_LOG2:0] FIFO occupancy
//   not_empty                combinational count != 0
// The master modport drives the inputs (UART and CPU side).
// The slave modport belongs to the FIFO.
interface simplez_kbd_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_rcv;
    logic                data_cs;
    logic                status_cs;
    logic [7:0]          dout;
    logic [7:0]          status;
    logic [DEPTH_LOG2:0] count;
    logic                not_empty;
    modport master (
        output rx_data, rx_rcv, data_cs, status_cs,
        input  dout, status, count, not_empty
    );
    modport slave (
        input  rx_data, rx_rcv, data_cs, status_cs,
        output dout, status, count, not_empty
    );
endinterface

// File: rtl/simplez_kbd_fifo.sv
// simplez_kbd_fifo: keyboard FIFO between the UART receiver and the Simplez CPU ports 510/511
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   simplez_kbd_fifo_if.slave
//         inputs:  rx_data, rx_rcv, data_cs, status_cs
//         outputs: dout, status, count, not_empty
module simplez_kbd_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic               clk,
    input logic               rstn,
    simplez_kbd_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] L_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [7:0]            r_dout;
    logic [7:0]            r_status;
    logic                  r_ovf;
    logic                  r_data_q;
    logic                  r_status_q;

    logic w_pop_req;
    logic w_stat_req;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // The CPU keeps its chip selects high for several cycles per access,
    // so only the rising edge counts as a request.
    assign w_pop_req  = bus.data_cs & ~r_data_q;
    assign w_stat_req = bus.status_cs & ~r_status_q;
    assign w_full     = r_count == L_FULL;
    assign w_empty    = r_count == '0;
    assign w_pop      = w_pop_req & ~w_empty;
    // When the FIFO is full, a pop on the same edge frees the slot the push needs.
    assign w_push     = bus.rx_rcv & (~w_full | w_pop);
    assign w_drop     = bus.rx_rcv & w_full & ~w_pop;

    // Storage carries no reset: stale entries are never read, because the
    // pointers and the count are cleared.
    always_ff @(posedge clk) begin
        if (rstn && w_push) r_mem[r_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_status   <= '0;
            r_ovf      <= 1'b0;
            r_data_q   <= 1'b0;
            r_status_q <= 1'b0;
        end else begin
            r_data_q   <= bus.data_cs;
            r_status_q <= bus.status_cs;
            if (w_pop_req) r_dout <= w_pop ? r_mem[r_rd_ptr] : 8'h00;
            if (w_pop) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            r_count <= r_count + (DEPTH_LOG2 + 1)'(w_push) - (DEPTH_LOG2 + 1)'(w_pop);
            // Status takes the flags from before this edge, so an overflow
            // is reported before the same status read clears it.
            if (bus.status_cs) r_status <= {5'b0, r_ovf, w_full, ~w_empty};
            r_ovf <= w_drop ? 1'b1 : (w_stat_req ? 1'b0 : r_ovf);
        end
    end

    assign bus.dout      = r_dout;
    assign bus.status    = r_status;
    assign bus.count     = r_count;
    assign bus.not_empty = ~w_empty;
endmodule

// File: tb/tb_simplez_kbd_fifo.sv
// tb_simplez_kbd_fifo: directed-vector bench for simplez_kbd_fifo, with a queue reference model
module tb_simplez_kbd_fifo;
    localparam int DL = 4;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    simplez_kbd_fifo_if #(.DEPTH_LOG2(DL)) bus ();
    simplez_kbd_fifo #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holds the buffered bytes. A pop takes the oldest
    // byte before a push is appended, so a full FIFO accepts a push that
    // coincides with a pop.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;
    logic [7:0] m_status = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_dq = 1'b0;
    bit         m_sq = 1'b0;

    always @(posedge clk) begin : model
        int n;
        bit drop;
        if (!rstn) begin
            q.delete();
            m_dout   <= 8'h00;
            m_status <= 8'h00;
            m_ovf    <= 1'b0;
            m_dq     <= 1'b0;
            m_sq     <= 1'b0;
        end else begin
            n = q.size();
            drop = 1'b0;
            if (bus.status_cs) m_status <= {5'b0, m_ovf, n == DEPTH, n != 0};
            if (bus.data_cs && !m_dq) m_dout <= (n != 0) ? q.pop_front() : 8'h00;
            if (bus.rx_rcv) begin
                if (q.size() < DEPTH) q.push_back(bus.rx_data);
                else drop = 1'b1;
            end
            m_ovf <= drop ? 1'b1 : ((bus.status_cs && !m_sq) ? 1'b0 : m_ovf);
            m_dq  <= bus.data_cs;
            m_sq  <= bus.status_cs;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", bus.dout, m_dout);
            check("status", bus.status, m_status);
            check("count", bus.count, q.size());
            check("not_empty", bus.not_empty, q.size() != 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rcv = 1'b1;
        cyc();
        bus.rx_rcv = 1'b0;
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        bus.data_cs = 1'b1;
        cyc();
        check("pop_dout", bus.dout, exp);
        bus.data_cs = 1'b0;
        cyc();
    endtask

    task automatic stat_chk(input logic [7:0] exp);
        bus.status_cs = 1'b1;
        cyc();
        check("stat_read", bus.status, exp);
        bus.status_cs = 1'b0;
        cyc();
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_rcv = 1'b0;
        bus.data_cs = 1'b0;
        bus.status_cs = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_dout", bus.dout, 8'h00);
        check("rst_status", bus.status, 8'h00);
        check("rst_count", bus.count, 0);
        rstn = 1'b1;
        cyc();
        // A single byte; status held for three cycles; data_cs held for four cycles.
        push(8'h41);
        bus.status_cs = 1'b1;
        repeat (3) cyc();
        check("status_ready", bus.status, 8'h01);
        bus.status_cs = 1'b0;
        bus.data_cs = 1'b1;
        cyc();
        check("dout_41", bus.dout, 8'h41);
        check("count_after_pop", bus.count, 0);
        repeat (3) cyc();
        check("single_pop_count", bus.count, 0);
        check("single_pop_dout", bus.dout, 8'h41);
        bus.data_cs = 1'b0;
        cyc();
        // Three bytes, three separate reads.
        push(8'h61);
        push(8'h62);
        push(8'h63);
        pop_chk(8'h61);
        pop_chk(8'h62);
        pop_chk(8'h63);
        stat_chk(8'h00);
        // Overfill: seventeen pushes leave sixteen bytes, drop 8'h10 and set overflow.
        for (int i = 0; i < 17; i++) push(8'(i));
        check("full_count", bus.count, 16);
        stat_chk(8'h07);
        stat_chk(8'h03);
        // Full FIFO: a push on the same edge as a pop is accepted.
        bus.rx_data = 8'hAA;
        bus.rx_rcv = 1'b1;
        bus.data_cs = 1'b1;
        cyc();
        check("full_pushpop_dout", bus.dout, 8'h00);
        check("full_pushpop_count", bus.count, 16);
        bus.rx_rcv = 1'b0;
        bus.data_cs = 1'b0;
        cyc();
        stat_chk(8'h03);
        for (int i = 1; i < 16; i++) pop_chk(8'(i));
        pop_chk(8'hAA);
        // Empty FIFO: a pop returns 8'h00, including when a push lands on the same edge.
        pop_chk(8'h00);
        check("empty_pop_count", bus.count, 0);
        bus.rx_data = 8'h55;
        bus.rx_rcv = 1'b1;
        bus.data_cs = 1'b1;
        cyc();
        check("empty_pushpop_dout", bus.dout, 8'h00);
        check("empty_pushpop_count", bus.count, 1);
        bus.rx_rcv = 1'b0;
        bus.data_cs = 1'b0;
        cyc();
        pop_chk(8'h55);
        // Reset in the middle of a push stream; the rx_rcv in the reset cycle is ignored.
        push(8'h11);
        push(8'h12);
        bus.status_cs = 1'b1;
        push(8'h13);
        bus.status_cs = 1'b0;
        rstn = 1'b0;
        bus.rx_data = 8'h14;
        bus.rx_rcv = 1'b1;
        cyc();
        rstn = 1'b1;
        bus.rx_rcv = 1'b0;
        check("midrst_count", bus.count, 0);
        check("midrst_dout", bus.dout, 8'h00);
        check("midrst_status", bus.status, 8'h00);
        push(8'h77);
        pop_chk(8'h77);
        // Twenty push/pop pairs carry both pointers past the wrap point.
        for (int i = 0; i < 20; i++) begin
            push(8'(i * 7 + 3));
            pop_chk(8'(i * 7 + 3));
        end
        // An overflowing push on the edge of a status rising edge keeps overflow set.
        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        bus.rx_data = 8'hEE;
        bus.rx_rcv = 1'b1;
        bus.status_cs = 1'b1;
        cyc();
        check("ovf_coincide_status", bus.status, 8'h03);
        bus.rx_rcv = 1'b0;
        bus.status_cs = 1'b0;
        cyc();
        stat_chk(8'h07);
        stat_chk(8'h03);
        pop_chk(8'hC0);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
